spi_master_tx: RTL and testbench
================================

// Module: spi_master_tx
// PURPOSE
// - Transmit-only SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
// - Sits directly downstream of display_controller.
// - Consumes its tx_start/tx_data/dc byte stream and returns tx_busy.
// - Drives the panel's SCLK, MOSI, CS and D/C pins; D/C is captured per byte so it stays stable for the whole frame.
// PARAMETERS
// - CLK_DIV  2  clk cycles per SCLK half-period; legal range >= 1.
// - CS_HOLD  1  clk cycles CS stays low after the last SCLK falling edge; legal range >= 1.
// PORTS
// - clk       in   1  system clock; all state updates on posedge.
// - reset     in   1  asynchronous, active-low reset (0 = in reset).
// - tx_start  in   1  byte request; sampled only in IDLE.
// - tx_data   in   8  byte to send; sampled with tx_start.
// - dc_in     in   1  data/command flag for the byte (1 = data); sampled with tx_start.
// - tx_busy   out  1  high from the cycle after accept until the frame completes.
// - spi_sclk  out  1  serial clock, idles low.
// - spi_mosi  out  1  serial data, equal to shreg[7].
// - spi_cs    out  1  chip select, active low.
// - spi_dc    out  1  registered copy of dc_in.
// BEHAVIOUR
// - All outputs are registered.
// - Reset values: tx_busy=0, spi_sclk=0, spi_mosi=0, spi_cs=1, spi_dc=0, state=IDLE, all counters 0.
// - States: IDLE, SHIFT_LO, SHIFT_HI, HOLD. Internal counters: shreg[7:0], bit_cnt[2:0], div_cnt, hold_cnt.
// - IDLE (cs=1, sclk=0, busy=0): on tx_start=1
//   - shreg<=tx_data, spi_dc<=dc_in, cs<=0, busy<=1
//   - bit_cnt<=7, div_cnt<=CLK_DIV-1, go to SHIFT_LO.
// - SHIFT_LO (sclk=0):
//   - div_cnt!=0: decrement.
//   - div_cnt==0: sclk<=1, div_cnt<=CLK_DIV-1, go to SHIFT_HI. The rising edge samples a MOSI bit that has been stable >= CLK_DIV cycles.
// - SHIFT_HI (sclk=1):
//   - div_cnt!=0: decrement.
//   - div_cnt==0: sclk<=0, then:
//     - bit_cnt!=0: shreg<=shreg<<1, bit_cnt--, div_cnt<=CLK_DIV-1, go to SHIFT_LO.
//     - bit_cnt==0: hold_cnt<=CS_HOLD-1, go to HOLD.
// - HOLD (sclk=0, cs=0):
//   - hold_cnt!=0: decrement.
//   - hold_cnt==0: cs<=1, busy<=0, shreg<=0, go to IDLE.
// - Latency: tx_busy is high for exactly 16*CLK_DIV+CS_HOLD cycles (defaults: 33). Exactly 8 SCLK rising edges per frame.
// - tx_start while busy (any non-IDLE state) is ignored; there is no queue. tx_data and dc_in may change freely after accept.
// - tx_start held high continuously: IDLE lasts exactly 1 cycle between frames (busy=0, cs=1 for 1 cycle), then the next byte is accepted.
// - spi_dc changes only on accept and holds its value after the frame ends.
// - Reset asserted mid-frame: immediate abort to reset values; cs rises asynchronously and the partial byte is discarded.
// - Counter widths: div_cnt $clog2(CLK_DIV+1), hold_cnt $clog2(CS_HOLD+1), minimum 1 bit each. No wrap-around is possible; counters only count down from their reload values.
// STRUCTURE
// - Shared header spi_defs.vh holds the state encoding `defines (IDLE/SHIFT_LO/SHIFT_HI/HOLD) and `SPI_CS_IDLE=1.
// - `COMMAND_BIT/`DATA_BIT are reused from the existing display command header; they are not redefined here.
// - Single flat module. The divider is one down-counter; no sub-module is warranted.
// TESTING
// - Bench replaces the tx_busy mock with this block and adds a shift-register SPI slave model sampling MOSI on SCLK rise.
// 1. Reset held low, then released:
//    - During reset: cs=1, sclk=0, busy=0, mosi=0, dc=0.
//    - After release with no tx_start: outputs stay at those values.
// 2. tx_start with tx_data=8'h01, dc_in=0 (SW reset cmd), defaults:
//    - Slave receives 8'h01 with dc=0 at every rising edge.
//    - busy high for 33 cycles; exactly 8 SCLK rises.
// 3. Back-to-back: tx_start held high, data 8'hF8 then 8'h00, dc_in=1:
//    - Two frames received, 8'hF8 then 8'h00.
//    - Exactly 1 cycle with cs=1 between frames.
// 4. tx_start pulsed with 8'hAA while busy with 8'h3A:
//    - Only 8'h3A is received; the pulse is ignored.
// 5. CLK_DIV=1, CS_HOLD=3, byte 8'h5C:
//    - busy high for 19 cycles; SCLK period 2 cycles.
//    - cs low for 3 cycles after the last fall.
// 6. Reset asserted after 4 SCLK rises of 8'hFF:
//    - Same-cycle cs=1, sclk=0, busy=0.
//    - Next tx_start sends a full, correct 8-bit frame.

Source files
------------

// File: rtl/spi_master_tx_pkg.sv
// Shared types and helpers for the transmit-only SPI master.
// State encoding and the counter-width rule live here so that every user agrees on them.
package spi_master_tx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    HOLD     = 2'd3
  } spi_state_e;

  localparam logic SPI_CS_IDLE = 1'b1;

  // Width of a down-counter that must hold values 0..n, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spi_master_tx.sv
// Transmit-only SPI master, mode 0, MSB first, 8-bit frames with per-byte D/C.
// One divider down-counter paces both SCLK half-periods; CS is held CS_HOLD cycles after the last fall.
module spi_master_tx
  import spi_master_tx_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_HOLD = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       dc_in,
  output logic       tx_busy,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs,
  output logic       spi_dc
);

  localparam int DW = cnt_width(CLK_DIV);
  localparam int HW = cnt_width(CS_HOLD);
  localparam logic [DW-1:0] DIV_LOAD  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(CS_HOLD - 1);

  spi_state_e      state, state_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic [2:0]      bit_cnt, bit_nxt;
  logic [DW-1:0]   div_cnt, div_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic            sclk_nxt, cs_nxt, busy_nxt, dc_nxt;
  logic            div_done, hold_done, last_bit;

  assign div_done  = (div_cnt == '0);
  assign hold_done = (hold_cnt == '0);
  assign last_bit  = (bit_cnt == 3'd0);
  // MOSI is the flop output of the shift register's top bit, so it is registered as well.
  assign spi_mosi  = shreg[7];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (tx_start)  state_nxt = SHIFT_LO;
      SHIFT_LO: if (div_done)  state_nxt = SHIFT_HI;
      SHIFT_HI: if (div_done)  state_nxt = last_bit ? HOLD : SHIFT_LO;
      HOLD:     if (hold_done) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shreg_nxt = shreg;
    bit_nxt   = bit_cnt;
    div_nxt   = div_cnt;
    hold_nxt  = hold_cnt;
    sclk_nxt  = spi_sclk;
    cs_nxt    = spi_cs;
    busy_nxt  = tx_busy;
    dc_nxt    = spi_dc;
    case (state)
      IDLE: begin
        if (tx_start) begin
          shreg_nxt = tx_data;
          dc_nxt    = dc_in;
          cs_nxt    = ~SPI_CS_IDLE;
          busy_nxt  = 1'b1;
          bit_nxt   = 3'd7;
          div_nxt   = DIV_LOAD;
        end
      end
      SHIFT_LO: begin
        if (div_done) begin
          sclk_nxt = 1'b1;
          div_nxt  = DIV_LOAD;
        end else begin
          div_nxt  = div_cnt - DW'(1);
        end
      end
      SHIFT_HI: begin
        if (!div_done) begin
          div_nxt = div_cnt - DW'(1);
        end else begin
          sclk_nxt = 1'b0;
          // Shift on the falling edge so the next bit is stable for a full low half-period.
          if (!last_bit) begin
            shreg_nxt = {shreg[6:0], 1'b0};
            bit_nxt   = bit_cnt - 3'd1;
            div_nxt   = DIV_LOAD;
          end else begin
            hold_nxt  = HOLD_LOAD;
          end
        end
      end
      HOLD: begin
        if (!hold_done) begin
          hold_nxt = hold_cnt - HW'(1);
        end else begin
          cs_nxt    = SPI_CS_IDLE;
          busy_nxt  = 1'b0;
          shreg_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      hold_cnt <= '0;
      spi_sclk <= 1'b0;
      spi_cs   <= SPI_CS_IDLE;
      tx_busy  <= 1'b0;
      spi_dc   <= 1'b0;
    end else begin
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_nxt;
      div_cnt  <= div_nxt;
      hold_cnt <= hold_nxt;
      spi_sclk <= sclk_nxt;
      spi_cs   <= cs_nxt;
      tx_busy  <= busy_nxt;
      spi_dc   <= dc_nxt;
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: default instance plus a CLK_DIV=1/CS_HOLD=3 instance,
// each with a frame-timing model and an SPI slave that samples MOSI on SCLK rise.
module tb_spi_master_tx;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] st    = '0;
  logic [1:0] dci   = '0;
  logic [7:0] dat [2];
  logic [1:0] busy, sclk, mosi, cs, dco;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gd
    localparam int D = (g == 0) ? 2 : 1;
    localparam int H = (g == 0) ? 1 : 3;
    localparam int N = 16 * D + H;

    spi_master_tx #(.CLK_DIV(D), .CS_HOLD(H)) dut (
      .clk(clk), .reset(rst_n), .tx_start(st[g]), .tx_data(dat[g]), .dc_in(dci[g]),
      .tx_busy(busy[g]), .spi_sclk(sclk[g]), .spi_mosi(mosi[g]), .spi_cs(cs[g]), .spi_dc(dco[g])
    );

    // Model: k counts cycles since accept (0 = idle); frame lasts N cycles.
    int         k   = 0;
    logic [7:0] md  = '0;
    logic       mdc = 1'b0;
    int         ph;
    logic       e_sclk, e_mosi;

    int rises = 0, last_rises = 0, rx_n = 0;
    int run = 0, last_run = 0, gap = 0, last_gap = 0;
    logic [7:0] sh = '0;
    logic [7:0] rx [16];
    logic       rx_dc [16];

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        k = 0; mdc = 1'b0;
      end else if (k == 0) begin
        if (st[g]) begin k = 1; md = dat[g]; mdc = dci[g]; end
      end else if (k == N) begin
        k = 0;
      end else begin
        k++;
      end
    end

    always @(negedge clk) begin
      e_sclk = 1'b0;
      e_mosi = 1'b0;
      if (k != 0 && k <= 16 * D) begin
        ph     = (k - 1) / D;
        e_sclk = ph[0];
        e_mosi = md[7 - ph / 2];
      end else if (k != 0) begin
        e_mosi = md[0];
      end
      chk($sformatf("busy_u%0d", g), busy[g], k != 0);
      chk($sformatf("cs_u%0d", g),   cs[g],   k == 0);
      chk($sformatf("sclk_u%0d", g), sclk[g], e_sclk);
      chk($sformatf("mosi_u%0d", g), mosi[g], e_mosi);
      chk($sformatf("dc_u%0d", g),   dco[g],  mdc);
      if (busy[g]) run++;
      else if (run != 0) begin last_run = run; run = 0; end
      if (cs[g]) gap++;
      else if (gap != 0) begin last_gap = gap; gap = 0; end
    end

    always @(posedge sclk[g]) begin
      sh = {sh[6:0], mosi[g]};
      rises++;
      chk($sformatf("dc_at_rise_u%0d", g), dco[g], mdc);
    end

    always @(negedge cs[g]) rises = 0;

    always @(posedge cs[g]) begin
      last_rises = rises;
      if (rises == 8 && rx_n < 16) begin
        rx[rx_n]    = sh;
        rx_dc[rx_n] = dco[g];
        rx_n++;
      end
    end
  end

  task automatic send(input int g, input logic [7:0] d, input logic c);
    @(negedge clk);
    st[g] = 1'b1; dat[g] = d; dci[g] = c;
    @(negedge clk);
    st[g] = 1'b0; dat[g] = ~d; dci[g] = ~c;
  endtask

  task automatic wait_idle(input int g);
    int t = 0;
    while (busy[g] && t < 300) begin @(negedge clk); t++; end
    chk("idle_reached", busy[g], 1'b0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    int t;
    dat[0] = '0; dat[1] = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs", cs, 2'b11);
    chk("rst_sclk", sclk, 2'b00);
    chk("rst_busy", busy, 2'b00);
    chk("rst_mosi", mosi, 2'b00);
    chk("rst_dc", dco, 2'b00);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_cs", cs, 2'b11);
    chk("idle_sclk", sclk, 2'b00);
    chk("idle_busy", busy, 2'b00);

    // Single command byte
    send(0, 8'h01, 1'b0);
    wait_idle(0);
    chk("t2_rx_n", gd[0].rx_n, 1);
    chk("t2_byte", gd[0].rx[0], 8'h01);
    chk("t2_dc", gd[0].rx_dc[0], 1'b0);
    chk("t2_busy_len", gd[0].last_run, 33);
    chk("t2_rises", gd[0].last_rises, 8);

    // Back-to-back with tx_start held
    @(negedge clk); st[0] = 1'b1; dat[0] = 8'hF8; dci[0] = 1'b1;
    @(negedge clk); dat[0] = 8'h00;
    t = 0;
    while (busy[0] && t < 300) begin @(negedge clk); t++; end
    chk("t3_gap_idle", busy[0], 1'b0);
    @(negedge clk); st[0] = 1'b0;
    chk("t3_second_accept", busy[0], 1'b1);
    wait_idle(0);
    chk("t3_rx_n", gd[0].rx_n, 3);
    chk("t3_byte0", gd[0].rx[1], 8'hF8);
    chk("t3_byte1", gd[0].rx[2], 8'h00);
    chk("t3_dc", {gd[0].rx_dc[1], gd[0].rx_dc[2]}, 2'b11);
    chk("t3_cs_gap", gd[0].last_gap, 1);

    // Start pulse while busy is dropped
    send(0, 8'h3A, 1'b1);
    repeat (5) @(negedge clk);
    st[0] = 1'b1; dat[0] = 8'hAA; dci[0] = 1'b0;
    @(negedge clk); st[0] = 1'b0;
    wait_idle(0);
    repeat (40) @(negedge clk);
    chk("t4_rx_n", gd[0].rx_n, 4);
    chk("t4_byte", gd[0].rx[3], 8'h3A);
    chk("t4_dc_hold", dco[0], 1'b1);

    // Fast divider, long hold
    send(1, 8'h5C, 1'b1);
    wait_idle(1);
    chk("t5_rx_n", gd[1].rx_n, 1);
    chk("t5_byte", gd[1].rx[0], 8'h5C);
    chk("t5_busy_len", gd[1].last_run, 19);
    chk("t5_rises", gd[1].last_rises, 8);

    // Abort mid-frame with reset
    send(0, 8'hFF, 1'b0);
    t = 0;
    while (gd[0].rises < 4 && t < 300) begin @(negedge clk); t++; end
    chk("t6_four_rises", gd[0].rises, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_abort_cs", cs[0], 1'b1);
    chk("t6_abort_sclk", sclk[0], 1'b0);
    chk("t6_abort_busy", busy[0], 1'b0);
    chk("t6_abort_dc", dco[0], 1'b0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_discard", gd[0].rx_n, 4);
    send(0, 8'hC3, 1'b1);
    wait_idle(0);
    chk("t6_rx_n", gd[0].rx_n, 5);
    chk("t6_byte", gd[0].rx[4], 8'hC3);
    chk("t6_busy_len", gd[0].last_run, 33);
    chk("t6_rises", gd[0].last_rises, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
